// File: rtl/otter_alu_pkg.sv
// Shared definitions for the OTTER ALU and its two-requester arbiter.
package otter_alu_pkg;

  // ALU function codes; any code above SRA is illegal.
  typedef enum logic [3:0] {
    ADD  = 4'b0000,
    SUB  = 4'b0001,
    AND  = 4'b0010,
    OR   = 4'b0011,
    SLL  = 4'b0100,
    SLT  = 4'b0101,
    XOR  = 4'b0110,
    SLTU = 4'b0111,
    SRL  = 4'b1000,
    SRA  = 4'b1001
  } ALU_FUN;

  // Result returned for an illegal function code.
  localparam logic [31:0] ALU_ILLEGAL_RESULT = 32'hDEAD_DEAD;

  // Single-entry output stage occupancy.
  typedef enum logic {
    STAGE_EMPTY = 1'b0,
    STAGE_FULL  = 1'b1
  } stage_state_e;

endpackage

// File: rtl/OTTER_ALU.sv
// Purely combinational OTTER ALU with illegal-code detection and raw zero flag.
module OTTER_ALU
  import otter_alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  fun_i,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        illegal_o
);

  // Decode the function code; shifts use only the low five bits of B.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    result_o  = ALU_ILLEGAL_RESULT;
    illegal_o = 1'b0;
    case (fun_i)
      ADD:     result_o = a_i + b_i;
      SUB:     result_o = a_i - b_i;
      AND:     result_o = a_i & b_i;
      OR:      result_o = a_i | b_i;
      SLL:     result_o = a_i << b_i[4:0];
      SLT:     result_o = {31'b0, $signed(a_i) < $signed(b_i)};
      XOR:     result_o = a_i ^ b_i;
      SLTU:    result_o = {31'b0, a_i < b_i};
      SRL:     result_o = a_i >> b_i[4:0];
      SRA:     result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      default: illegal_o = 1'b1;
    endcase
  end

  // Raw zero flag, before any per-request inversion.
  assign zero_o = (result_o == 32'h0);

endmodule

// File: rtl/otter_alu_arbiter.sv
// Two-requester arbiter time-sharing one OTTER_ALU behind a single-entry
// result register, with per-requester saturating completion counters.
module otter_alu_arbiter
  import otter_alu_pkg::*;
#(
  parameter int          FIXED_PRIORITY = 0,
  parameter int unsigned SAT_COUNT_W    = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             REQ_VALID,
  input  logic [31:0]            REQ_A0,
  input  logic [31:0]            REQ_A1,
  input  logic [31:0]            REQ_B0,
  input  logic [31:0]            REQ_B1,
  input  logic [3:0]             REQ_FUN0,
  input  logic [3:0]             REQ_FUN1,
  input  logic [1:0]             REQ_INVZ,
  output logic [1:0]             REQ_READY,
  output logic [1:0]             RSP_VALID,
  input  logic [1:0]             RSP_READY,
  output logic [31:0]            RSP_RESULT,
  output logic                   RSP_ZERO,
  output logic                   RSP_ILLEGAL,
  output logic [SAT_COUNT_W-1:0] DONE_CNT0,
  output logic [SAT_COUNT_W-1:0] DONE_CNT1
);

  stage_state_e           state_q;
  logic                   owner_q;
  logic                   last_q;    // requester granted on the last accept
  logic [31:0]            result_q;
  logic                   zero_q;
  logic                   illegal_q;
  logic [SAT_COUNT_W-1:0] cnt0_q, cnt0_d;
  logic [SAT_COUNT_W-1:0] cnt1_q, cnt1_d;

  logic [1:0]  grant;
  logic        drain;
  logic        stage_open;
  logic        accept;
  logic        sel;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_fun;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_illegal;

  // Pick a winner: sole requester, else fixed priority or round-robin.
  always_comb begin
    grant = 2'b00;
    case (REQ_VALID)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (FIXED_PRIORITY != 0 || last_q) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign drain      = (state_q == STAGE_FULL) && RSP_READY[owner_q];
  assign stage_open = !RST && ((state_q == STAGE_EMPTY) || drain);
  assign REQ_READY  = grant & {2{stage_open}};
  assign accept     = |REQ_READY;
  assign sel        = REQ_READY[1];

  assign alu_a   = sel ? REQ_A1   : REQ_A0;
  assign alu_b   = sel ? REQ_B1   : REQ_B0;
  assign alu_fun = sel ? REQ_FUN1 : REQ_FUN0;

  OTTER_ALU u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .fun_i    (alu_fun),
    .result_o (alu_result),
    .zero_o   (alu_zero),
    .illegal_o(alu_illegal)
  );

  // Output stage FSM: capture on accept, empty on drain, hold otherwise.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (RST) begin
      // NOTE: the result register is reset too, since its value is visible
      // on RSP_RESULT straight out of reset.
      state_q   <= STAGE_EMPTY;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      result_q  <= 32'h0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      state_q   <= STAGE_FULL;
      owner_q   <= sel;
      last_q    <= sel;
      result_q  <= alu_result;
      zero_q    <= alu_zero ^ (sel ? REQ_INVZ[1] : REQ_INVZ[0]);
      illegal_q <= alu_illegal;
    end else if (drain) begin
      state_q   <= STAGE_EMPTY;
    end
  end

  // Count drains per owner, sticking at all-ones.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (drain && !owner_q && !(&cnt0_q)) cnt0_d = cnt0_q + SAT_COUNT_W'(1);
    if (drain &&  owner_q && !(&cnt1_q)) cnt1_d = cnt1_q + SAT_COUNT_W'(1);
  end

  // Counter registers; reset discards any held, undrained result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign RSP_VALID   = {(state_q == STAGE_FULL) &&  owner_q,
                        (state_q == STAGE_FULL) && !owner_q};
  assign RSP_RESULT  = result_q;
  assign RSP_ZERO    = zero_q;
  assign RSP_ILLEGAL = illegal_q;
  assign DONE_CNT0   = cnt0_q;
  assign DONE_CNT1   = cnt1_q;

endmodule

// File: tb/tb_otter_alu_arbiter.sv
// Directed scoreboard bench for otter_alu_arbiter (round-robin, 2-bit
// counters) with a fixed-priority instance alongside for grant order.
module tb_otter_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b11;
  logic [31:0] a0 = 32'h0, a1 = 32'h0, b0 = 32'h0, b1 = 32'h0;
  logic [3:0]  f0 = 4'h0, f1 = 4'h0;
  logic [1:0]  invz = 2'b00;
  logic [1:0]  rsp_ready = 2'b11;

  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_illegal;
  logic [1:0]  cnt0, cnt1;

  logic [1:0]  fp_req_ready, fp_rsp_valid;
  logic [31:0] fp_rsp_result;
  logic        fp_rsp_zero, fp_rsp_illegal;
  logic [15:0] fp_cnt0, fp_cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
  } exp_t;

  exp_t exp_q[$];

  otter_alu_arbiter #(.FIXED_PRIORITY(0), .SAT_COUNT_W(2)) dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid),
    .REQ_A0(a0), .REQ_A1(a1), .REQ_B0(b0), .REQ_B1(b1),
    .REQ_FUN0(f0), .REQ_FUN1(f1), .REQ_INVZ(invz),
    .REQ_READY(req_ready), .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
    .RSP_RESULT(rsp_result), .RSP_ZERO(rsp_zero), .RSP_ILLEGAL(rsp_illegal),
    .DONE_CNT0(cnt0), .DONE_CNT1(cnt1)
  );

  otter_alu_arbiter #(.FIXED_PRIORITY(1), .SAT_COUNT_W(16)) dut_fp (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid),
    .REQ_A0(a0), .REQ_A1(a1), .REQ_B0(b0), .REQ_B1(b1),
    .REQ_FUN0(f0), .REQ_FUN1(f1), .REQ_INVZ(invz),
    .REQ_READY(fp_req_ready), .RSP_VALID(fp_rsp_valid), .RSP_READY(rsp_ready),
    .RSP_RESULT(fp_rsp_result), .RSP_ZERO(fp_rsp_zero), .RSP_ILLEGAL(fp_rsp_illegal),
    .DONE_CNT0(fp_cnt0), .DONE_CNT1(fp_cnt1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference of the ALU function table.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] f);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a << b[4:0];
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return a ^ b;
      4'd7:    return (a < b) ? 32'd1 : 32'd0;
      4'd8:    return a >> b[4:0];
      4'd9:    return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'hDEAD_DEAD;
    endcase
  endfunction

  function automatic exp_t make_exp(input int idx);
    exp_t e;
    e.valid   = (idx == 1) ? 2'b10 : 2'b01;
    e.result  = (idx == 1) ? alu_ref(a1, b1, f1) : alu_ref(a0, b0, f0);
    e.illegal = ((idx == 1) ? f1 : f0) > 4'd9;
    e.zero    = (e.result == 32'h0) ^ invz[idx];
    return e;
  endfunction

  task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] f, input logic inv);
    if (idx == 1) begin a1 = a; b1 = b; f1 = f; end
    else          begin a0 = a; b0 = b; f0 = f; end
    invz[idx] = inv;
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, " RSP_VALID idle"}, 32'(rsp_valid), 32'd0);
    end else begin
      e = exp_q[0];
      chk({tag, " RSP_VALID"},   32'(rsp_valid),   32'(e.valid));
      chk({tag, " RSP_RESULT"},  rsp_result,       e.result);
      chk({tag, " RSP_ZERO"},    32'(rsp_zero),    32'(e.zero));
      chk({tag, " RSP_ILLEGAL"}, 32'(rsp_illegal), 32'(e.illegal));
    end
  endtask

  // One cycle: check combinational ready, update the scoreboard, then check
  // the registered response just after the edge.
  task automatic step(input string tag, input logic [1:0] exp_ready,
                      input logic [1:0] exp_fp_ready);
    @(negedge clk);
    chk({tag, " REQ_READY"},    32'(req_ready),    32'(exp_ready));
    chk({tag, " REQ_READY fp"}, 32'(fp_req_ready), 32'(exp_fp_ready));
    if (exp_q.size() != 0 && (rsp_ready & exp_q[0].valid) != 2'b00)
      void'(exp_q.pop_front());
    if (exp_ready[0])      exp_q.push_back(make_exp(0));
    else if (exp_ready[1]) exp_q.push_back(make_exp(1));
    @(posedge clk); #1;
    check_rsp(tag);
  endtask

  task automatic reset_step(input string tag);
    rst = 1'b1;
    @(negedge clk);
    chk({tag, " REQ_READY"}, 32'(req_ready), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    chk({tag, " RSP_VALID"},   32'(rsp_valid),   32'd0);
    chk({tag, " RSP_RESULT"},  rsp_result,       32'd0);
    chk({tag, " RSP_ZERO"},    32'(rsp_zero),    32'd0);
    chk({tag, " RSP_ILLEGAL"}, 32'(rsp_illegal), 32'd0);
    chk({tag, " DONE_CNT0"},   32'(cnt0),        32'd0);
    chk({tag, " DONE_CNT1"},   32'(cnt1),        32'd0);
  endtask

  initial begin
    // Reset with both requesters valid: nothing may be accepted.
    reset_step("reset");
    reset_step("reset2");
    rst = 1'b0;

    // Single op: 5 - 3 from requester 0.
    req_valid = 2'b01; rsp_ready = 2'b11;
    set_op(0, 32'd5, 32'd3, 4'b0001, 1'b0);
    step("single_sub", 2'b01, 2'b01);
    req_valid = 2'b00;
    step("single_drain", 2'b00, 2'b00);
    chk("single DONE_CNT0", 32'(cnt0), 32'd1);

    // Backpressure: ADD 7+9 held three cycles while requester 0 keeps asking.
    req_valid = 2'b01; rsp_ready = 2'b10;
    set_op(0, 32'd7, 32'd9, 4'b0000, 1'b0);
    step("bp_add", 2'b01, 2'b01);
    set_op(0, 32'd1, 32'h21, 4'b0100, 1'b0);     // SLL uses only B[4:0]
    for (int i = 0; i < 3; i++) step("bp_hold", 2'b00, 2'b00);
    rsp_ready = 2'b11;
    step("bp_resume_sll", 2'b01, 2'b01);
    chk("bp DONE_CNT0", 32'(cnt0), 32'd2);
    set_op(0, 32'hF0, 32'hFFFF_FFE4, 4'b1000, 1'b0);  // SRL by 4
    step("srl", 2'b01, 2'b01);
    chk("sat DONE_CNT0 at 3", 32'(cnt0), 32'd3);
    set_op(0, 32'd1, 32'hFFFF_FFFF, 4'b0111, 1'b0);   // SLTU
    step("sltu", 2'b01, 2'b01);
    set_op(0, 32'hFFFF_FFFF, 32'd1, 4'b0101, 1'b0);   // SLT -1 < 1
    step("slt", 2'b01, 2'b01);
    set_op(0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0010, 1'b0);
    step("and", 2'b01, 2'b01);
    chk("sat DONE_CNT0 held", 32'(cnt0), 32'd3);
    chk("sat DONE_CNT1", 32'(cnt1), 32'd0);

    // Reset while FULL: held AND result is discarded, not counted.
    req_valid = 2'b00; rsp_ready = 2'b00;
    step("full_hold", 2'b00, 2'b00);
    req_valid = 2'b11;
    reset_step("reset_full");
    rst = 1'b0;

    // Contention: round-robin alternates from 0; fixed priority always 0.
    rsp_ready = 2'b11;
    set_op(0, 32'h1200, 32'h0034, 4'b0011, 1'b0);       // OR
    set_op(1, 32'h8000_0000, 32'd4, 4'b1001, 1'b0);     // SRA
    step("cont0", 2'b01, 2'b01);
    step("cont1", 2'b10, 2'b01);
    step("cont2", 2'b01, 2'b01);
    step("cont3", 2'b10, 2'b01);
    req_valid = 2'b00;
    step("cont_drain", 2'b00, 2'b00);
    chk("cont DONE_CNT0", 32'(cnt0), 32'd2);
    chk("cont DONE_CNT1", 32'(cnt1), 32'd2);

    // Illegal code, inverted zero, and plain zero on requester 1.
    req_valid = 2'b10;
    set_op(1, 32'd123, 32'd456, 4'b1111, 1'b0);
    step("illegal", 2'b10, 2'b10);
    set_op(1, 32'd8, 32'd8, 4'b0110, 1'b1);             // XOR, inverted zero
    step("xor_invz", 2'b10, 2'b10);
    set_op(1, 32'd5, 32'd5, 4'b0001, 1'b0);             // SUB -> raw zero
    step("sub_zero", 2'b10, 2'b10);
    req_valid = 2'b00;
    step("final_drain", 2'b00, 2'b00);
    chk("final DONE_CNT1 sat", 32'(cnt1), 32'd3);
    chk("final DONE_CNT0", 32'(cnt0), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
